// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if: byte-level link between the SPI slave bit shifter and
// the frame controller. The shifter drives the master modport: it supplies
// the synchronised chip select and the received bytes, and it takes back the
// bytes to transmit on MISO. The frame controller uses the slave modport.
interface spi_frame_ctrl_if;
    logic       cs_n;       // chip select, active-low, synchronised to clk
    logic [7:0] rx_byte;    // byte just received by the shifter
    logic       rx_valid;   // one-cycle pulse, rx_byte is valid
    logic [7:0] tx_byte;    // next byte for the shifter, MSB first
    logic       tx_load;    // one-cycle pulse, shifter loads tx_byte

    modport master (
        output cs_n,
        output rx_byte,
        output rx_valid,
        input  tx_byte,
        input  tx_load
    );

    modport slave (
        input  cs_n,
        input  rx_byte,
        input  rx_valid,
        output tx_byte,
        output tx_load
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: command/frame controller downstream of the SPI slave byte
// shifter. Decodes the first byte of each frame (WRCMD / RDCMD), assembles a
// 64-bit big-endian write word, or snapshots the 64-bit read word and feeds
// it back byte by byte for MISO.
// Optional build macro: SPI_FRAME_ERR_EN enables the saturating frame-error
// counter on err_count; without it err_count is tied to zero.
module spi_frame_ctrl #(
    parameter logic [7:0] WRCMD = 8'h01,
    parameter logic [7:0] RDCMD = 8'h02
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_frame_ctrl_if.slave      bus,
    input  logic [63:0]          rd_data,
    output logic [63:0]          wr_data,
    output logic                 wr_strobe,
    output logic                 rd_snap,
    output logic [7:0]           err_count
);

    // Frame states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    logic [2:0]  state_q,     state_d;
    logic [2:0]  idx_q,       idx_d;
    logic [63:0] acc_q,       acc_d;
    logic [63:0] snap_q,      snap_d;
    logic [63:0] wr_data_q,   wr_data_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        rd_snap_q,   rd_snap_d;
    logic [7:0]  tx_byte_q,   tx_byte_d;
    logic        tx_load_q,   tx_load_d;

    // Helpers for the datapath
    logic        cs_abort;     // chip select dropped mid-frame
    logic [63:0] acc_next;     // accumulator with the current byte shifted in
    logic [2:0]  idx_inc;      // next byte index
    logic [5:0]  snap_shamt;   // bit offset of the next snapshot byte
    logic [63:0] snap_shifted; // snapshot aligned so the next byte is on top

    // Datapath helpers shared by the next-state logic
    always_comb begin
        cs_abort     = (state_q != S_IDLE) && bus.cs_n;
        acc_next     = {acc_q[55:0], bus.rx_byte};
        idx_inc      = idx_q + 3'd1;
        snap_shamt   = {idx_inc, 3'b000};
        snap_shifted = snap_q << snap_shamt;
    end

    // Frame sequencing: next-state, accumulator, snapshot and output pulses
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        snap_d      = snap_q;
        wr_data_d   = wr_data_q;
        wr_strobe_d = 1'b0;
        rd_snap_d   = 1'b0;
        tx_byte_d   = tx_byte_q;
        tx_load_d   = 1'b0;

        // Deassertion of cs_n outranks any coincident rx_valid, so it is
        // handled ahead of the per-state byte processing.
        if (cs_abort) begin
            state_d   = S_IDLE;
            idx_d     = 3'd0;
            acc_d     = '0;
            tx_byte_d = 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    idx_d     = 3'd0;
                    acc_d     = '0;
                    tx_byte_d = 8'h00;
                    if (!bus.cs_n) begin
                        state_d = S_CMD;
                    end
                end

                S_CMD: begin
                    if (bus.rx_valid) begin
                        idx_d = 3'd0;
                        acc_d = '0;
                        if (bus.rx_byte == WRCMD) begin
                            state_d = S_WR;
                        end else if (bus.rx_byte == RDCMD) begin
                            // First read byte goes out on the decode edge so
                            // the shifter has it before the next SCLK edge.
                            state_d   = S_RD;
                            snap_d    = rd_data;
                            rd_snap_d = 1'b1;
                            tx_byte_d = rd_data[63:56];
                            tx_load_d = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end

                S_WR: begin
                    if (bus.rx_valid) begin
                        if (idx_q == 3'd7) begin
                            wr_data_d   = acc_next;
                            wr_strobe_d = 1'b1;
                            acc_d       = '0;
                            idx_d       = 3'd0;
                            state_d     = S_DONE;
                        end else begin
                            acc_d = acc_next;
                            idx_d = idx_inc;
                        end
                    end
                end

                S_RD: begin
                    if (bus.rx_valid) begin
                        tx_load_d = 1'b1;
                        if (idx_q == 3'd7) begin
                            // Eighth dummy byte: all data has gone out.
                            tx_byte_d = 8'h00;
                            idx_d     = 3'd0;
                            state_d   = S_DONE;
                        end else begin
                            tx_byte_d = snap_shifted[63:56];
                            idx_d     = idx_inc;
                        end
                    end
                end

                S_DONE, S_IGNORE: begin
                    tx_byte_d = 8'h00;
                end

                default: begin
                    state_d   = S_IDLE;
                    idx_d     = 3'd0;
                    acc_d     = '0;
                    tx_byte_d = 8'h00;
                end
            endcase
        end
    end

    // Frame state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            acc_q       <= '0;
            snap_q      <= '0;
            wr_data_q   <= '0;
            wr_strobe_q <= 1'b0;
            rd_snap_q   <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            snap_q      <= snap_d;
            wr_data_q   <= wr_data_d;
            wr_strobe_q <= wr_strobe_d;
            rd_snap_q   <= rd_snap_d;
            tx_byte_q   <= tx_byte_d;
            tx_load_q   <= tx_load_d;
        end
    end

    assign wr_data     = wr_data_q;
    assign wr_strobe   = wr_strobe_q;
    assign rd_snap     = rd_snap_q;
    assign bus.tx_byte = tx_byte_q;
    assign bus.tx_load = tx_load_q;

`ifdef SPI_FRAME_ERR_EN
    logic [7:0] err_count_q, err_count_d;
    logic       frame_err;

    // A frame error is an unknown command byte or a short frame, i.e. cs_n
    // rising after a valid command but before the frame completed.
    always_comb begin
        frame_err = 1'b0;
        if (cs_abort) begin
            frame_err = (state_q == S_WR) || (state_q == S_RD);
        end else if ((state_q == S_CMD) && bus.rx_valid) begin
            frame_err = (bus.rx_byte != WRCMD) && (bus.rx_byte != RDCMD);
        end
    end

    // Saturating error counter update
    always_comb begin
        err_count_d = err_count_q;
        if (frame_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 8'h00;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed self-checking bench for spi_frame_ctrl.
// Inputs change on the falling clock edge; outputs are sampled on the
// falling edge after the rising edge that produced them.
module tb_spi_frame_ctrl;

`ifdef SPI_FRAME_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [63:0] rd_data;
    logic [63:0] wr_data;
    logic        wr_strobe;
    logic        rd_snap;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    // Pulse counters maintained by the monitor, sampled at the falling edge
    int n_wr   = 0;
    int n_snap = 0;
    int n_load = 0;

    spi_frame_ctrl_if bus ();

    spi_frame_ctrl #(
        .WRCMD (8'h01),
        .RDCMD (8'h02)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .rd_data   (rd_data),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .rd_snap   (rd_snap),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) n_wr++;
        if (rd_snap === 1'b1)   n_snap++;
        if (bus.tx_load === 1'b1) n_load++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte from the shifter; returns at the falling edge where the
    // response to that byte is visible. Leaves a one-cycle gap before the
    // next pulse.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus.cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd_exp [9];
        int w0, s0, l0;

        rd_exp = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};

        rst_n        = 1'b0;
        bus.cs_n     = 1'b1;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        rd_data      = 64'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_data",   wr_data,     64'h0);
        chk("rst_wr_strobe", wr_strobe,   64'h0);
        chk("rst_rd_snap",   rd_snap,     64'h0);
        chk("rst_tx_byte",   bus.tx_byte, 64'h0);
        chk("rst_tx_load",   bus.tx_load, 64'h0);
        chk("rst_err",       err_count,   64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full write frame: 0x01 + 8 x 0xFF
        w0 = n_wr;
        bus.cs_n = 1'b0;
        send(8'h01);
        chk("wr_cmd_tx", bus.tx_byte, 64'h0);
        for (int i = 0; i < 8; i++) begin
            send(8'hFF);
            chk("wr_tx_zero", bus.tx_byte, 64'h0);
            chk("wr_strobe_timing", wr_strobe, (i == 7) ? 64'h1 : 64'h0);
        end
        chk("wr_data_ff", wr_data, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wr_strobe_1cyc", wr_strobe, 64'h0);
        end_frame();
        chk("wr_strobe_count", 64'(n_wr - w0), 64'd1);

        // Read frame with rd_data changed after the snapshot
        s0 = n_snap;
        l0 = n_load;
        rd_data  = 64'h0123_4567_89AB_CDEF;
        bus.cs_n = 1'b0;
        send(8'h02);
        chk("rd_snap_pulse", rd_snap, 64'h1);
        chk("rd_byte0", bus.tx_byte, {56'h0, rd_exp[0]});
        chk("rd_load0", bus.tx_load, 64'h1);
        rd_data = 64'hDEAD_BEEF_5A5A_A5A5;
        for (int i = 1; i < 9; i++) begin
            send(8'h00);
            chk("rd_byte", bus.tx_byte, {56'h0, rd_exp[i]});
            chk("rd_load", bus.tx_load, 64'h1);
        end
        send(8'h00);
        chk("rd_done_tx", bus.tx_byte, 64'h0);
        chk("rd_done_noload", bus.tx_load, 64'h0);
        end_frame();
        chk("rd_snap_count", 64'(n_snap - s0), 64'd1);
        chk("rd_load_count", 64'(n_load - l0), 64'd9);
        chk("rd_wr_data_kept", wr_data, 64'hFFFF_FFFF_FFFF_FFFF);

        // Aborted write
        w0 = n_wr;
        bus.cs_n = 1'b0;
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        end_frame();
        chk("abort_no_strobe", 64'(n_wr - w0), 64'd0);
        chk("abort_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort_err", err_count, 64'(ERR_EN * 1));

        // Unknown command 0x55 followed by 8 bytes
        w0 = n_wr;
        s0 = n_snap;
        l0 = n_load;
        bus.cs_n = 1'b0;
        send(8'h55);
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h30 + i));
            chk("unk_tx_zero", bus.tx_byte, 64'h0);
        end
        end_frame();
        chk("unk_no_wr", 64'(n_wr - w0), 64'd0);
        chk("unk_no_snap", 64'(n_snap - s0), 64'd0);
        chk("unk_no_load", 64'(n_load - l0), 64'd0);
        chk("unk_err", err_count, 64'(ERR_EN * 2));

        // Overrun: 10 data bytes, only the first 8 are used
        w0 = n_wr;
        bus.cs_n = 1'b0;
        send(8'h01);
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h10 + i));
        end
        end_frame();
        chk("ovr_wr_data", wr_data, 64'h1011_1213_1415_1617);
        chk("ovr_one_strobe", 64'(n_wr - w0), 64'd1);
        chk("ovr_err", err_count, 64'(ERR_EN * 2));

        // rx_valid coincident with cs_n rising on the 8th data byte
        w0 = n_wr;
        bus.cs_n = 1'b0;
        send(8'h01);
        for (int i = 0; i < 7; i++) begin
            send(8'(8'h20 + i));
        end
        @(negedge clk);
        bus.rx_byte  = 8'h27;
        bus.rx_valid = 1'b1;
        bus.cs_n     = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("sim_no_strobe_now", wr_strobe, 64'h0);
        @(negedge clk);
        @(negedge clk);
        chk("sim_no_strobe", 64'(n_wr - w0), 64'd0);
        chk("sim_wr_data", wr_data, 64'h1011_1213_1415_1617);
        chk("sim_err", err_count, 64'(ERR_EN * 3));

        // Reset in the middle of a read
        rd_data  = 64'h0123_4567_89AB_CDEF;
        bus.cs_n = 1'b0;
        send(8'h02);
        send(8'h00);
        send(8'h00);
        chk("mid_rd_byte", bus.tx_byte, 64'h45);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_wr_data",   wr_data,     64'h0);
        chk("mrst_wr_strobe", wr_strobe,   64'h0);
        chk("mrst_rd_snap",   rd_snap,     64'h0);
        chk("mrst_tx_byte",   bus.tx_byte, 64'h0);
        chk("mrst_tx_load",   bus.tx_load, 64'h0);
        chk("mrst_err",       err_count,   64'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        bus.cs_n = 1'b1;
        @(negedge clk);

        // Fresh write after reset
        w0 = n_wr;
        bus.cs_n = 1'b0;
        send(8'h01);
        for (int i = 0; i < 8; i++) begin
            send(8'(8'hA0 + i));
        end
        chk("post_strobe", wr_strobe, 64'h1);
        chk("post_wr_data", wr_data, 64'hA0A1_A2A3_A4A5_A6A7);
        end_frame();
        chk("post_strobe_count", 64'(n_wr - w0), 64'd1);
        chk("post_err", err_count, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
